cheriot_dmem_responder: RTL and testbench

CHERIOT_DMEM_RESPONDER -- requirements
Module: cheriot_dmem_responder

---
 rtl/cheri_pkg.sv | 16 +
 rtl/cheriot_dmem_responder_if.sv | 27 ++
 rtl/cheriot_dmem_rsp_pipe.sv | 31 +++
 rtl/cheriot_dmem_responder.sv | 99 +++++++++
 tb/tb_cheriot_dmem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cheri_pkg.sv
// rtl/cheri_pkg.sv - shared types and constants for the CHERIoT data-memory responder
package cheri_pkg;

  // Bit position of the capability tag within a 33-bit memory word
  localparam int DMEM_TAG_BIT = 32;

  // One response beat as it travels down the response pipe
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [32:0] rdata;
  } dmem_rsp_t;

  localparam dmem_rsp_t DMEM_RSP_IDLE = '0;

endpackage

// File: rtl/cheriot_dmem_responder_if.sv
// rtl/cheriot_dmem_responder_if.sv - core data-port bundle between a CHERIoT core and its data memory
interface cheriot_dmem_responder_if;

  logic        data_req_i;
  logic        data_is_cap_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [32:0] data_wdata_i;
  logic [32:0] data_rdata_o;
  logic        data_err_o;

  // Core side: issues requests, receives grants and responses
  modport master (
    output data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  // Memory side: accepts requests, returns grants and responses
  modport slave (
    input  data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

endinterface

// File: rtl/cheriot_dmem_rsp_pipe.sv
// rtl/cheriot_dmem_rsp_pipe.sv - fixed-depth response delay line; depth sets grant-to-rvalid latency
module cheriot_dmem_rsp_pipe
  import cheri_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  dmem_rsp_t rsp_i,
  output dmem_rsp_t rsp_o
);

  dmem_rsp_t stage_q [Depth];

  // Shift every beat one stage per cycle; reset drops anything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= DMEM_RSP_IDLE;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/cheriot_dmem_responder.sv
// rtl/cheriot_dmem_responder.sv - tagged 33-bit data memory with fixed-latency responses; optional grant stall via CHERIOT_DMEM_GNT_STALL_EN
module cheriot_dmem_responder
  import cheri_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h2000_0000,
  parameter int unsigned MemWords       = 16384,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned GntStallCycles = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  cheriot_dmem_responder_if.slave   bus
);

  localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [32:0] MemBytes = 33'(MemWords) * 33'd4;

  if (RspLatency < 1 || RspLatency > 4) begin : g_bad_latency
    $error("RspLatency must be in 1..4");
  end

  logic [32:0] mem_q [MemWords];
  logic [31:0] offset;
  logic        in_range;
  logic [IdxW-1:0] idx;
  logic        xfer;
  logic        gnt;
  dmem_rsp_t   rsp_d;
  dmem_rsp_t   rsp_q;

  // Address decode: byte offset from the base, low two bits dropped for the word index
  assign offset   = bus.data_addr_i - MemBase;
  assign in_range = (bus.data_addr_i >= MemBase) && ({1'b0, offset} < MemBytes);
  assign idx      = offset[IdxW+1:2];

`ifdef CHERIOT_DMEM_GNT_STALL_EN
  localparam int unsigned CntW = (GntStallCycles > 0) ? $clog2(GntStallCycles + 1) : 1;
  logic [CntW-1:0] stall_q;

  // Each grant opens a window of idle cycles before the next grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (xfer) begin
      stall_q <= CntW'(GntStallCycles);
    end else if (stall_q != '0) begin
      stall_q <= stall_q - CntW'(1);
    end
  end

  assign gnt = bus.data_req_i & (stall_q == '0);
`else
  assign gnt = bus.data_req_i;
`endif

  assign xfer           = bus.data_req_i & gnt;
  assign bus.data_gnt_o = gnt;

  // Byte-lane write; the tag survives only a full-word capability store
  always_ff @(posedge clk_i) begin
    if (xfer && bus.data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
      mem_q[idx][DMEM_TAG_BIT] <= (bus.data_be_i == 4'hF) & bus.data_is_cap_i &
                                  bus.data_wdata_i[DMEM_TAG_BIT];
    end
  end

  // Form the response beat in the grant cycle; idle beats are all-zero
  always_comb begin
    rsp_d = DMEM_RSP_IDLE;
    if (xfer) begin
      rsp_d.valid = 1'b1;
      if (!in_range) begin
        rsp_d.err = 1'b1;
      end else if (!bus.data_we_i) begin
        rsp_d.rdata[31:0]         = mem_q[idx][31:0];
        rsp_d.rdata[DMEM_TAG_BIT] = bus.data_is_cap_i & mem_q[idx][DMEM_TAG_BIT];
      end
    end
  end

  cheriot_dmem_rsp_pipe #(
    .Depth (RspLatency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rsp_i  (rsp_d),
    .rsp_o  (rsp_q)
  );

  assign bus.data_rvalid_o = rsp_q.valid;
  assign bus.data_err_o    = rsp_q.err;
  assign bus.data_rdata_o  = rsp_q.rdata;

endmodule

// File: tb/tb_cheriot_dmem_responder.sv
// tb/tb_cheriot_dmem_responder.sv - scoreboard bench for cheriot_dmem_responder
module tb_cheriot_dmem_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int unsigned WORDS = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_r;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_r[$];

  cheriot_dmem_responder_if bus_a ();
  cheriot_dmem_responder_if bus_r ();
  cheriot_dmem_responder_if bus_s ();

  cheriot_dmem_responder #(
    .MemBase(BASE), .MemWords(WORDS), .RspLatency(3), .GntStallCycles(0)
  ) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));

  cheriot_dmem_responder #(
    .MemBase(BASE), .MemWords(WORDS), .RspLatency(2), .GntStallCycles(0)
  ) dut_r (.clk_i(clk), .rst_ni(rst_r), .bus(bus_r));

  cheriot_dmem_responder #(
    .MemBase(BASE), .MemWords(WORDS), .RspLatency(1), .GntStallCycles(2)
  ) dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(bus_s));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.data_rvalid_o) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = q_a.pop_front();
        chk({e.name, "_rdata"}, 64'(bus_a.data_rdata_o), 64'(e.rdata));
        chk({e.name, "_err"}, 64'(bus_a.data_err_o), 64'(e.err));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("a_idle_zero", 64'({bus_a.data_err_o, bus_a.data_rdata_o}), 64'd0);
    end
  end

  // Monitor for the latency-2 reset instance
  always @(negedge clk) begin
    exp_t e;
    if (bus_r.data_rvalid_o) begin
      if (q_r.size() == 0) begin
        chk("r_unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = q_r.pop_front();
        chk({e.name, "_rdata"}, 64'(bus_r.data_rdata_o), 64'(e.rdata));
        chk({e.name, "_err"}, 64'(bus_r.data_err_o), 64'(e.err));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("r_idle_zero", 64'({bus_r.data_err_o, bus_r.data_rdata_o}), 64'd0);
    end
  end

  task automatic issue_a(input string name, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [32:0] wdata, input logic cap,
                         input logic [32:0] exp_rdata, input logic exp_err);
    exp_t e;
    bus_a.data_req_i    = 1'b1;
    bus_a.data_we_i     = we;
    bus_a.data_be_i     = be;
    bus_a.data_addr_i   = addr;
    bus_a.data_wdata_i  = wdata;
    bus_a.data_is_cap_i = cap;
    @(negedge clk);
    chk({name, "_gnt"}, 64'(bus_a.data_gnt_o), 64'd1);
    if (bus_a.data_gnt_o) begin
      e = '{exp_rdata, exp_err, cyc + 3, name};
      q_a.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_r(input string name, input logic we, input logic [31:0] addr,
                         input logic [32:0] wdata, input logic [32:0] exp_rdata, input logic push);
    exp_t e;
    bus_r.data_req_i    = 1'b1;
    bus_r.data_we_i     = we;
    bus_r.data_be_i     = 4'hF;
    bus_r.data_addr_i   = addr;
    bus_r.data_wdata_i  = wdata;
    bus_r.data_is_cap_i = 1'b1;
    @(negedge clk);
    chk({name, "_gnt"}, 64'(bus_r.data_gnt_o), 64'd1);
    if (bus_r.data_gnt_o && push) begin
      e = '{exp_rdata, 1'b0, cyc + 2, name};
      q_r.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input int n);
    bus_a.data_req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_r(input int n);
    bus_r.data_req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic exp_gnt [6];

  initial begin
`ifdef CHERIOT_DMEM_GNT_STALL_EN
    exp_gnt = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst_n = 1'b0;
    rst_r = 1'b0;
    bus_a.data_req_i = 1'b0; bus_a.data_we_i = 1'b0; bus_a.data_be_i = '0;
    bus_a.data_addr_i = '0; bus_a.data_wdata_i = '0; bus_a.data_is_cap_i = 1'b0;
    bus_r.data_req_i = 1'b0; bus_r.data_we_i = 1'b0; bus_r.data_be_i = '0;
    bus_r.data_addr_i = '0; bus_r.data_wdata_i = '0; bus_r.data_is_cap_i = 1'b0;
    bus_s.data_req_i = 1'b0; bus_s.data_we_i = 1'b0; bus_s.data_be_i = '0;
    bus_s.data_addr_i = BASE; bus_s.data_wdata_i = '0; bus_s.data_is_cap_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid_a", 64'(bus_a.data_rvalid_o), 64'd0);
    chk("reset_gnt_a", 64'(bus_a.data_gnt_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_r = 1'b1;

    // Tag handling, partial writes, decode boundaries
    issue_a("wr_cap",      1'b1, 4'hF, BASE + 32'h10, 33'h1_DEADBEEF, 1'b1, 33'h0, 1'b0);
    issue_a("rd_cap",      1'b0, 4'hF, BASE + 32'h10, 33'h0, 1'b1, 33'h1_DEADBEEF, 1'b0);
    issue_a("rd_nocap",    1'b0, 4'hF, BASE + 32'h10, 33'h0, 1'b0, 33'h0_DEADBEEF, 1'b0);
    issue_a("wr_byte0",    1'b1, 4'b0001, BASE + 32'h10, 33'h1_00000055, 1'b1, 33'h0, 1'b0);
    issue_a("rd_cap_part", 1'b0, 4'hF, BASE + 32'h10, 33'h0, 1'b1, 33'h0_DEADBE55, 1'b0);
    issue_a("rd_unalign",  1'b0, 4'hF, BASE + 32'h13, 33'h0, 1'b0, 33'h0_DEADBE55, 1'b0);
    issue_a("wr_nocapf",   1'b1, 4'hF, BASE + 32'h14, 33'h1_CAFEF00D, 1'b0, 33'h0, 1'b0);
    issue_a("rd_nocapf",   1'b0, 4'hF, BASE + 32'h14, 33'h0, 1'b1, 33'h0_CAFEF00D, 1'b0);
    issue_a("wr_first",    1'b1, 4'hF, BASE, 33'h1_11112222, 1'b1, 33'h0, 1'b0);
    issue_a("wr_last",     1'b1, 4'hF, BASE + 32'd252, 33'h1_33334444, 1'b1, 33'h0, 1'b0);
    issue_a("wr_oor_hi",   1'b1, 4'hF, BASE + 32'd256, 33'h0_AAAAAAAA, 1'b0, 33'h0, 1'b1);
    issue_a("wr_oor_lo",   1'b1, 4'hF, BASE - 32'd4, 33'h0_BBBBBBBB, 1'b0, 33'h0, 1'b1);
    issue_a("rd_oor_lo",   1'b0, 4'hF, BASE - 32'd4, 33'h0, 1'b1, 33'h0, 1'b1);
    issue_a("rd_oor_hi",   1'b0, 4'hF, BASE + 32'd256, 33'h0, 1'b1, 33'h0, 1'b1);
    issue_a("rd_first",    1'b0, 4'hF, BASE, 33'h0, 1'b1, 33'h1_11112222, 1'b0);
    issue_a("rd_last",     1'b0, 4'hF, BASE + 32'd252, 33'h0, 1'b1, 33'h1_33334444, 1'b0);
    idle_a(5);

    // Four back-to-back reads after an idle gap
    issue_a("b2b_0", 1'b0, 4'hF, BASE + 32'h10, 33'h0, 1'b1, 33'h0_DEADBE55, 1'b0);
    issue_a("b2b_1", 1'b0, 4'hF, BASE + 32'h14, 33'h0, 1'b1, 33'h0_CAFEF00D, 1'b0);
    issue_a("b2b_2", 1'b0, 4'hF, BASE, 33'h0, 1'b1, 33'h1_11112222, 1'b0);
    issue_a("b2b_3", 1'b0, 4'hF, BASE + 32'd252, 33'h0, 1'b0, 33'h0_33334444, 1'b0);
    idle_a(6);

    // Reset during an in-flight read
    issue_r("r_wr", 1'b1, BASE + 32'h20, 33'h1_0BADCAFE, 33'h0, 1'b1);
    idle_r(4);
    issue_r("r_rd_killed", 1'b0, BASE + 32'h20, 33'h0, 33'h0, 1'b0);
    bus_r.data_req_i = 1'b0;
    rst_r = 1'b0;
    #1;
    chk("r_reset_rvalid_now", 64'(bus_r.data_rvalid_o), 64'd0);
    @(negedge clk);
    chk("r_reset_rvalid", 64'(bus_r.data_rvalid_o), 64'd0);
    chk("r_reset_rdata", 64'(bus_r.data_rdata_o), 64'd0);
    @(posedge clk);
    #1;
    rst_r = 1'b1;
    idle_r(5);
    issue_r("r_rd_persist", 1'b0, BASE + 32'h20, 33'h0, 33'h1_0BADCAFE, 1'b1);
    idle_r(4);

    // Grant pattern with request held high
    bus_s.data_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall_gnt_%0d", i), 64'(bus_s.data_gnt_o), 64'(exp_gnt[i]));
    end
    @(posedge clk);
    #1;
    bus_s.data_req_i = 1'b0;

    for (int i = 0; i < 20 && (q_a.size() != 0 || q_r.size() != 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_a", 64'(q_a.size()), 64'd0);
    chk("drain_r", 64'(q_r.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
